figure_pos_ctrl: RTL and testbench
==================================

# figure_pos_ctrl

Frame-synchronous position and animation controller for the figure sprite layer. It accepts move commands from game logic through a valid/ready handshake and buffers one of them. It commits the buffered move only at the start of vertical blanking, so the figure never tears mid-frame. It drives the figure origin and animation-frame index consumed by the figure renderer and its ROM addressing.

## Interface
Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- FIG_W, 128, figure width in screen pixels
- FIG_H, 64, figure height in screen pixels
- STEP, 4, pixels moved per committed command
- INIT_X, 336, reset x origin
- INIT_Y, 268, reset y origin
- ANIM_DIV, 8, frames per animation step (≥1)
- ANIM_FRAMES, 4, animation frame count (power of two, ≤4)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vblnk  in  1  vertical blanking from VGA timing
- freeze  in  1  suspends commits and animation
- cmd_valid  in  1  move command present
- cmd_dir  in  2  00 left, 01 right, 10 up, 11 down
- cmd_ready  out  1  buffer empty, command may be accepted
- fig_x  out  11  figure left edge
- fig_y  out  11  figure top edge
- anim_frame  out  2  current animation frame
- frame_tick  out  1  one-cycle pulse per frame start

## Operation
- Reset values: fig_x=INIT_X, fig_y=INIT_Y, anim_frame=0, frame_tick=0, cmd_ready=1, state IDLE. The buffer, frame counter and vblnk_d are all cleared.
- Reset asserted mid-operation: any buffered command is discarded and all outputs return to their reset values immediately (asynchronous).
- Frame edge detection: vblnk_d is registered each cycle. Rise is defined as vblnk & ~vblnk_d.
- FSM states:
  - IDLE: buffer empty, cmd_ready=1. On cmd_valid, latch cmd_dir and go to HELD.
  - HELD: cmd_ready=0. On rise & ~freeze, go to APPLY. Otherwise stay.
  - APPLY: fig_x/fig_y take the clamped value at the end of this cycle. The next state is IDLE.
- Clamp arithmetic is done in 12 bits:
  - left: x<STEP ? 0 : x-STEP
  - right: x+STEP > SCREEN_W-FIG_W ? SCREEN_W-FIG_W : x+STEP
  - up and down are the same rules on y with SCREEN_H-FIG_H.
- A move into a wall still commits, with no position change, and frees the buffer.
- Only one command is buffered per frame. Further cmd_valid is back-pressured until return to IDLE.
- A command accepted in the same cycle as rise is not applied this frame. It waits in HELD for the next rise.
- Animation runs on every rise with freeze=0:
  - frame_cnt increments, wrapping at ANIM_DIV-1 back to 0.
  - On wrap, anim_frame increments modulo ANIM_FRAMES.
- freeze=1: rise is ignored for commits and for animation, frame_tick stays low, and the buffered command is retained. Acceptance in IDLE continues.

## Timing
- frame_tick is high for exactly the one cycle after the cycle in which rise is true.
- Commit latency: rise in cycle N, APPLY in N+1, fig_x/fig_y updated and visible from N+2.
- cmd_ready returns to 1 in cycle N+2.
- anim_frame updates in cycle N+1, registered off rise.
- Handshake: a transfer occurs on a clock edge where cmd_valid & cmd_ready. cmd_ready falls in the following cycle. cmd_ready never depends combinationally on cmd_valid.
- Outputs are stable through the whole active frame. They change only within the first three cycles of vblnk.
- If vblnk is held high across reset release, it is not treated as a rise.

## Test plan
- Reset, then idle for 2 frames → fig_x=336, fig_y=268, cmd_ready=1, frame_tick pulses once per frame, anim_frame=0.
- Send one right command mid-frame → cmd_ready=0 until commit. fig_x=340 two cycles after the vblnk rise, unchanged before it.
- Start with fig_x=2 and send left → fig_x=0. Then send left again → fig_x=0 and cmd_ready returns to 1.
- Start with fig_y=534 and send down twice over two frames → fig_y=536, then 536.
- Hold cmd_valid continuously with alternating directions → exactly one command is accepted per frame. A command accepted in the vblnk rise cycle is applied only at the following frame.
- Run 32 frames with freeze low for frames 0-15 and high for 16-31 → anim_frame=2 after 16 frames, then frozen. A command buffered while frozen is retained. Asserting rst mid-HELD clears the buffer and restores 336/268.

Source files
------------

// File: rtl/figure_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : figure_pos_ctrl
// Function : Buffers one figure move per frame, commits it at the start of
//            vertical blanking, and steps the sprite animation frame index.
// Revision : 1.0 - initial release
// ============================================================================
module figure_pos_ctrl #(
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int FIG_W       = 128,
    parameter int FIG_H       = 64,
    parameter int STEP        = 4,
    parameter int INIT_X      = 336,
    parameter int INIT_Y      = 268,
    parameter int ANIM_DIV    = 8,
    parameter int ANIM_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        freeze,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_dir,
    output logic        cmd_ready,
    output logic [10:0] fig_x,
    output logic [10:0] fig_y,
    output logic [1:0]  anim_frame,
    output logic        frame_tick
);

    localparam int               c_CNT_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [11:0]      c_MAX_X     = 12'(SCREEN_W - FIG_W);
    localparam logic [11:0]      c_MAX_Y     = 12'(SCREEN_H - FIG_H);
    localparam logic [11:0]      c_STEP      = 12'(STEP);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ANIM_DIV - 1);
    localparam logic [1:0]       c_ANIM_MASK = 2'(ANIM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_latch;
    logic [1:0]         r_dir;
    logic               r_vblnk_d;
    logic               r_armed;
    logic               w_rise;
    logic               w_step;
    logic [c_CNT_W-1:0] r_frame_cnt;
    logic [1:0]         r_anim;
    logic               r_tick;
    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic [10:0]        w_x_nxt;
    logic [10:0]        w_y_nxt;
    logic [11:0]        w_x_ext;
    logic [11:0]        w_y_ext;
    logic [11:0]        w_x_inc;
    logic [11:0]        w_y_inc;

    // r_armed hides a vblnk that is already high when reset is released
    assign w_rise    = vblnk & ~r_vblnk_d & r_armed;
    assign w_step    = w_rise & ~freeze;
    assign cmd_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vblnk_d <= 1'b0;
            r_armed   <= 1'b0;
            r_state   <= IDLE;
            r_dir     <= 2'b00;
        end else begin
            r_vblnk_d <= vblnk;
            r_armed   <= 1'b1;
            r_state   <= w_state_nxt;
            if (w_latch) begin
                r_dir <= cmd_dir;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (w_step) begin
                    w_state_nxt = APPLY;
                end
            end
            APPLY:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};
    assign w_x_inc = w_x_ext + c_STEP;
    assign w_y_inc = w_y_ext + c_STEP;

    // Clamped target; a move into a wall yields the unchanged position
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        case (r_dir)
            2'b00:   w_x_nxt = (w_x_ext < c_STEP) ? 11'd0 : 11'(w_x_ext - c_STEP);
            2'b01:   w_x_nxt = (w_x_inc > c_MAX_X) ? 11'(c_MAX_X) : 11'(w_x_inc);
            2'b10:   w_y_nxt = (w_y_ext < c_STEP) ? 11'd0 : 11'(w_y_ext - c_STEP);
            default: w_y_nxt = (w_y_inc > c_MAX_Y) ? 11'(c_MAX_Y) : 11'(w_y_inc);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= 11'(INIT_X);
            r_y <= 11'(INIT_Y);
        end else if (r_state == APPLY) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_anim      <= 2'd0;
            r_tick      <= 1'b0;
        end else begin
            r_tick <= w_step;
            if (w_step) begin
                if (r_frame_cnt == c_CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_anim      <= (r_anim + 2'd1) & c_ANIM_MASK;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign fig_x      = r_x;
    assign fig_y      = r_y;
    assign anim_frame = r_anim;
    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_figure_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_figure_pos_ctrl
// Function : Self-checking bench for figure_pos_ctrl (centre and near-wall
//            instances driven in parallel against a frame-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_figure_pos_ctrl;

    localparam int STEP = 4;
    localparam int MAXX = 800 - 128;
    localparam int MAXY = 600 - 64;
    localparam int DIV  = 8;
    localparam int NFR  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic        freeze = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_dir = 2'b00;
    logic        cmd_ready, w_ready;
    logic [10:0] fig_x, fig_y, w_x, w_y;
    logic [1:0]  anim_frame, w_anim;
    logic        frame_tick, w_tick;

    always #5 clk = ~clk;

    figure_pos_ctrl dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .freeze(freeze),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
        .fig_x(fig_x), .fig_y(fig_y), .anim_frame(anim_frame), .frame_tick(frame_tick)
    );

    figure_pos_ctrl #(.INIT_X(2), .INIT_Y(534)) dut_w (
        .clk(clk), .rst(rst), .vblnk(vblnk), .freeze(freeze),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(w_ready),
        .fig_x(w_x), .fig_y(w_y), .anim_frame(w_anim), .frame_tick(w_tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = centre instance, index 1 = near-wall instance
    int m_x[2];
    int m_y[2];
    int pend[$];
    bit m_sched;
    int m_at;
    int cyc = 0;
    int m_rises;
    bit m_prev, m_armed, m_tick;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_x[0] = 336; m_y[0] = 268;
        m_x[1] = 2;   m_y[1] = 534;
        pend.delete();
        m_sched = 1'b0;
        m_rises = 0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_tick  = 1'b0;
    endtask

    task automatic apply_move(input int d);
        for (int i = 0; i < 2; i++) begin
            case (d)
                0:       m_x[i] = (m_x[i] - STEP < 0) ? 0 : m_x[i] - STEP;
                1:       m_x[i] = (m_x[i] + STEP > MAXX) ? MAXX : m_x[i] + STEP;
                2:       m_y[i] = (m_y[i] - STEP < 0) ? 0 : m_y[i] - STEP;
                default: m_y[i] = (m_y[i] + STEP > MAXY) ? MAXY : m_y[i] + STEP;
            endcase
        end
    endtask

    task automatic model_step();
        bit pre_ready, pre_sched, rise;
        pre_ready = (pend.size() == 0);
        pre_sched = m_sched;
        rise      = vblnk && !m_prev && m_armed;
        if (pre_sched && m_at == cyc) begin
            apply_move(pend.pop_front());
            m_sched = 1'b0;
        end else if (!pre_ready && !pre_sched && rise && !freeze) begin
            m_sched = 1'b1;
            m_at    = cyc + 1;
        end
        if (cmd_valid && pre_ready) pend.push_back(int'(cmd_dir));
        m_tick = rise && !freeze;
        if (m_tick) m_rises++;
        m_prev  = vblnk;
        m_armed = 1'b1;
    endtask

    task automatic compare_all();
        int rdy, anim;
        rdy  = (pend.size() == 0) ? 1 : 0;
        anim = (m_rises / DIV) % NFR;
        chk("fig_x", int'(fig_x), m_x[0]);
        chk("fig_y", int'(fig_y), m_y[0]);
        chk("wall_fig_x", int'(w_x), m_x[1]);
        chk("wall_fig_y", int'(w_y), m_y[1]);
        chk("cmd_ready", int'(cmd_ready), rdy);
        chk("wall_cmd_ready", int'(w_ready), rdy);
        chk("anim_frame", int'(anim_frame), anim);
        chk("wall_anim_frame", int'(w_anim), anim);
        chk("frame_tick", int'(frame_tick), int'(m_tick));
        chk("wall_frame_tick", int'(w_tick), int'(m_tick));
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (rst) model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input bit vb);
        vblnk = vb;
        rst   = 1'b0;
        model_reset();
        #1;
        chk("async_reset_x", int'(fig_x), 336);
        chk("async_reset_y", int'(fig_y), 268);
        chk("async_reset_ready", int'(cmd_ready), 1);
        chk("async_reset_anim", int'(anim_frame), 0);
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic run_frame(input bit send, input logic [1:0] dir, input bit frz,
                             input int act, input int blk);
        freeze = frz;
        vblnk  = 1'b0;
        for (int i = 0; i < act; i++) begin
            if (send && i == 2) begin
                cmd_valid = 1'b1;
                cmd_dir   = dir;
            end
            cycle();
            cmd_valid = 1'b0;
        end
        vblnk = 1'b1;
        for (int i = 0; i < blk; i++) cycle();
    endtask

    typedef struct {
        int send; int dir; int frz;
        int x; int y; int wx; int wy; int anim; int rdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int acc;
        tbl[0] = '{0, 0, 0, 336, 268, 2, 534, 0, 1};
        tbl[1] = '{0, 0, 0, 336, 268, 2, 534, 0, 1};
        tbl[2] = '{1, 1, 0, 340, 268, 6, 534, 0, 1};
        tbl[3] = '{1, 0, 0, 336, 268, 2, 534, 0, 1};
        tbl[4] = '{1, 0, 0, 332, 268, 0, 534, 0, 1};
        tbl[5] = '{1, 0, 0, 328, 268, 0, 534, 0, 1};
        tbl[6] = '{1, 3, 0, 328, 272, 0, 536, 0, 1};
        tbl[7] = '{1, 3, 0, 328, 276, 0, 536, 1, 1};
        tbl[8] = '{1, 1, 1, 328, 276, 0, 536, 1, 0};
        tbl[9] = '{0, 0, 0, 332, 276, 4, 536, 1, 1};

        #2;
        do_reset(1'b0);

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].send != 0, 2'(tbl[i].dir), tbl[i].frz != 0, 10, 5);
            chk("tbl_x", int'(fig_x), tbl[i].x);
            chk("tbl_y", int'(fig_y), tbl[i].y);
            chk("tbl_wall_x", int'(w_x), tbl[i].wx);
            chk("tbl_wall_y", int'(w_y), tbl[i].wy);
            chk("tbl_anim", int'(anim_frame), tbl[i].anim);
            chk("tbl_ready", int'(cmd_ready), tbl[i].rdy);
        end

        // Command accepted in the very cycle vblnk rises waits a full frame
        freeze = 1'b0;
        vblnk  = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        vblnk     = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 2'd1;
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("rise_accept_not_applied_x", int'(fig_x), 332);
        chk("rise_accept_held_ready", int'(cmd_ready), 0);
        run_frame(1'b0, 2'd0, 1'b0, 8, 5);
        chk("rise_accept_applied_x", int'(fig_x), 336);
        chk("rise_accept_ready", int'(cmd_ready), 1);

        // Continuous cmd_valid with alternating directions
        cmd_valid = 1'b1;
        cmd_dir   = 2'd0;
        for (int f = 0; f < 4; f++) begin
            acc   = 0;
            vblnk = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (i == 10) vblnk = 1'b1;
                if (cmd_valid && cmd_ready) acc++;
                cycle();
                cmd_dir = cmd_dir ^ 2'd1;
            end
            if (f > 0) chk("accepts_per_frame", acc, 1);
        end
        cmd_valid = 1'b0;

        // Animation over 16 free frames, then a frozen buffered command
        do_reset(1'b0);
        for (int f = 0; f < 16; f++) run_frame(1'b0, 2'd0, 1'b0, 10, 5);
        chk("anim_after_16", int'(anim_frame), 2);
        run_frame(1'b1, 2'd1, 1'b1, 10, 5);
        for (int f = 17; f < 32; f++) run_frame(1'b0, 2'd0, 1'b1, 10, 5);
        chk("anim_frozen", int'(anim_frame), 2);
        chk("frozen_retained_ready", int'(cmd_ready), 0);
        chk("frozen_x", int'(fig_x), 336);

        // Reset while HELD, with vblnk high across reset release
        freeze = 1'b0;
        vblnk  = 1'b0;
        cycle();
        cycle();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("no_tick_after_reset", int'(frame_tick), 0);
        end
        run_frame(1'b0, 2'd0, 1'b0, 10, 5);
        chk("buffer_discarded_x", int'(fig_x), 336);
        chk("buffer_discarded_ready", int'(cmd_ready), 1);

        // Randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            int act, blk;
            act    = $urandom_range(20, 6);
            blk    = $urandom_range(8, 3);
            freeze = (($urandom % 4) == 0);
            vblnk  = 1'b0;
            for (int i = 0; i < act + blk; i++) begin
                if (i == act) vblnk = 1'b1;
                cmd_valid = 1'($urandom);
                cmd_dir   = 2'($urandom);
                cycle();
            end
        end
        cmd_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
